sector_write_deser: RTL and testbench
=====================================

# sector_write_deser

Parametrised write-path deserializer for the emulated drive. It sits between the write-data recovery logic and the sector buffer RAM. During the data area it hunts for the sync bit, assembles the serial write stream into WORD_W-bit words, and writes each word to sequential buffer addresses. At the end of the area it pads and stores any partial word, then pulses a flush with the stored word count; it also flags buffer overflow.

## Interface
- WORD_W, 8: bits per buffer word (2..32).
- ADDR_W, 9: buffer address width; buffer depth DEPTH = 2**ADDR_W words.
- SYNC_EN, 1: 1 = discard preamble zeros and the first 1 (sync bit); 0 = capture from the first bit of the area.
- MSB_FIRST, 1: 1 = first received bit lands in data_out[WORD_W-1]; 0 = lands in bit 0.
- PAD_BIT, 1'b0: fill value for the unreceived bits of a trailing partial word.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_data  in  1  serial write bit, valid when new_data=1.
- new_data  in  1  one-cycle strobe; a bit is accepted only when new_data=1 and data_area=1 in the same cycle.
- data_area  in  1  high for the duration of the sector data field.
- addr_out  out  ADDR_W  buffer write address, valid with wr_en.
- data_out  out  WORD_W  buffer write data, valid with wr_en.
- wr_en  out  1  one-cycle write strobe.
- wr_flush  out  1  one-cycle end-of-sector pulse.
- word_count  out  ADDR_W+1  words stored this sector (saturates at DEPTH); valid from wr_flush until next HUNT entry.
- overflow  out  1  sticky: at least one word was dropped because the buffer was full.

## Operation
- States: IDLE, HUNT, CAPTURE, PAD, FLUSH.
- IDLE: data_area=1 -> HUNT; on that entry clear word_count, overflow, address and bit counters.
- HUNT (SYNC_EN=1): accepted 0 bits are discarded; an accepted 1 is discarded and moves to CAPTURE. With SYNC_EN=0, IDLE goes directly to CAPTURE, and a bit accepted in the entry cycle is captured.
- CAPTURE: each accepted bit shifts in per MSB_FIRST. On the WORD_W-th bit, issue a write at the current address, then increment the address and word_count.
- If word_count=DEPTH, the completed word is dropped: no wr_en, overflow set, and the address does not wrap.
- data_area low in CAPTURE:
  - with bits pending (1..WORD_W-1) -> PAD;
  - with none pending -> FLUSH.
- data_area low in HUNT -> FLUSH; word_count stays 0.
- PAD: writes the pending bits, filled with PAD_BIT in the positions not yet received, following the overflow rule -> FLUSH.
- FLUSH: wr_flush=1 for one cycle -> IDLE. A data_area already high starts HUNT the following cycle.
- Bits are ignored whenever data_area=0 or the state is PAD or FLUSH.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - shift register and counters 0.
- Write latency: wr_en asserts the cycle after the accepted bit that completes a word. addr_out and data_out change only in that cycle and hold until the next write.
- End of area: let T be the first cycle with data_area=0.
  - With a partial word: PAD write at T+1, wr_flush at T+2.
  - Otherwise: wr_flush at T+1.
- wr_en and wr_flush are never high in the same cycle.
- Back-to-back words are limited only by new_data spacing (minimum one bit per cycle).
- Reset mid-sector: everything returns to reset values immediately. No flush is issued, and the next rising data_area begins a fresh sector.

## Structure
- fpgahawk_pkg holds:
  - the wr_state_t enum (IDLE, HUNT, CAPTURE, PAD, FLUSH);
  - a shared SYNC/PAD default constant.
- Sub-module word_shifter(WORD_W, MSB_FIRST, PAD_BIT):
  - shift register, bit counter, word-complete and pending flags;
  - padded-word output.
- The top level holds the FSM, address and count logic, overflow, and the output registers.

## Test plan
- SYNC_EN=1, WORD_W=8: 12 zeros, a 1, then bits of 0xA5 and 0x3C -> wr_en at addr 0 = 0xA5 and addr 1 = 0x3C; after the area ends, wr_flush with word_count=2 and overflow=0.
- 8 bits 0xFF then 3 bits 1,0,1 and area end, MSB_FIRST=1, PAD_BIT=0 -> word 0 = 0xFF; PAD write at T+1 to addr 1 = 0xA0; wr_flush at T+2 with word_count=2.
- ADDR_W=2 (DEPTH=4), 6 full words -> writes at addrs 0..3 only; overflow rises on word 5; word_count=4 at flush; addr_out stays 3.
- data_area pulse of 40 cycles containing only zeros -> no wr_en; wr_flush at T+1 with word_count=0.
- MSB_FIRST=0, SYNC_EN=0, bits 1,0,0,0,0,0,0,0 -> data_out=0x01; new_data coincident with the data_area falling edge is ignored (no extra pending bit, no PAD).
- rst asserted after 20 bits -> outputs 0 at once, no wr_flush; the next sector writes from addr 0 with word_count restarted.

Source files
------------

// File: rtl/fpgahawk_pkg.sv
// Shared types and defaults for the write-path deserializer.
// State encoding and parameter defaults live here.
package fpgahawk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    CAPTURE,
    PAD,
    FLUSH
  } wr_state_t;

  localparam logic DEF_SYNC_EN = 1'b1;
  localparam logic DEF_PAD_BIT = 1'b0;

endpackage

// File: rtl/word_shifter.sv
// Serial-to-parallel word assembler with bit counter.
// Exposes the completed word and a padded partial word.
module word_shifter #(
  parameter int unsigned WORD_W    = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        PAD_BIT   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic              word_done,
  output logic              pending,
  output logic [WORD_W-1:0] full_word,
  output logic [WORD_W-1:0] pad_word
);

  localparam int unsigned CW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);
  localparam logic [CW-1:0] FULL = CW'(WORD_W);

  logic [WORD_W-1:0] sr_q, sr_d, base_sr;
  logic [CW-1:0]     cnt_q, cnt_d, base_cnt;
  logic [CW-1:0]     gap;
  logic [WORD_W-1:0] ones;

  // Shift the incoming bit in and advance the bit counter.
  always_comb begin
    base_sr  = clr ? '0 : sr_q;
    base_cnt = clr ? '0 : cnt_q;
    if (MSB_FIRST) begin
      full_word = {base_sr[WORD_W-2:0], bit_in};
    end else begin
      full_word = {bit_in, base_sr[WORD_W-1:1]};
    end
    word_done = shift_en && (base_cnt == LAST);
    sr_d      = base_sr;
    cnt_d     = base_cnt;
    if (shift_en) begin
      sr_d  = full_word;
      cnt_d = word_done ? '0 : base_cnt + 1'b1;
    end
  end

  // Align the pending bits and fill the missing positions.
  always_comb begin
    ones    = '1;
    gap     = FULL - cnt_q;
    pending = (cnt_q != '0);
    if (MSB_FIRST) begin
      pad_word = (sr_q << gap)
               | (PAD_BIT ? (ones >> cnt_q) : '0);
    end else begin
      pad_word = (sr_q >> gap)
               | (PAD_BIT ? ~(ones >> gap) : '0);
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sector_write_deser.sv
// Sector write-path deserializer: sync hunt, word assembly,
// buffer writes, partial-word padding and end-of-sector flush.
module sector_write_deser
  import fpgahawk_pkg::*;
#(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned ADDR_W    = 9,
  parameter bit          SYNC_EN   = DEF_SYNC_EN,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        PAD_BIT   = DEF_PAD_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_data,
  input  logic              new_data,
  input  logic              data_area,
  output logic [ADDR_W-1:0] addr_out,
  output logic [WORD_W-1:0] data_out,
  output logic              wr_en,
  output logic              wr_flush,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  wr_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              overflow_q, overflow_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_flush_q, wr_flush_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic [WORD_W-1:0] data_out_q, data_out_d;

  logic              sh_clr, sh_en, start, do_write;
  logic              word_done, pending;
  logic [WORD_W-1:0] full_word, pad_word, wdata;

  word_shifter #(
    .WORD_W    (WORD_W),
    .MSB_FIRST (MSB_FIRST),
    .PAD_BIT   (PAD_BIT)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .clr       (sh_clr),
    .shift_en  (sh_en),
    .bit_in    (wr_data),
    .word_done (word_done),
    .pending   (pending),
    .full_word (full_word),
    .pad_word  (pad_word)
  );

  // Next state, buffer write issue, counters and overflow.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    wr_en_d      = 1'b0;
    wr_flush_d   = 1'b0;
    addr_out_d   = addr_out_q;
    data_out_d   = data_out_q;
    sh_clr       = 1'b0;
    sh_en        = 1'b0;
    start        = 1'b0;
    do_write     = 1'b0;
    wdata        = '0;
    unique case (state_q)
      IDLE: begin
        if (data_area) begin
          start = 1'b1;
          sh_en = !SYNC_EN && new_data;
        end
      end
      HUNT: begin
        if (!data_area) begin
          wr_flush_d = 1'b1;
          state_d    = FLUSH;
        end else if (new_data && wr_data) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!data_area) begin
          if (pending) begin
            do_write = 1'b1;
            wdata    = pad_word;
            state_d  = PAD;
          end else begin
            wr_flush_d = 1'b1;
            state_d    = FLUSH;
          end
        end else begin
          sh_en = new_data;
          if (word_done) begin
            do_write = 1'b1;
            wdata    = full_word;
          end
        end
      end
      PAD: begin
        wr_flush_d = 1'b1;
        state_d    = FLUSH;
      end
      FLUSH: begin
        state_d = IDLE;
        start   = data_area;
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      sh_clr       = 1'b1;
      addr_d       = '0;
      word_count_d = '0;
      overflow_d   = 1'b0;
      state_d      = SYNC_EN ? HUNT : CAPTURE;
    end
    if (do_write) begin
      if (word_count_q == DEPTH_C) begin
        overflow_d = 1'b1;
      end else begin
        wr_en_d      = 1'b1;
        addr_out_d   = addr_q;
        data_out_d   = wdata;
        addr_d       = addr_q + 1'b1;
        word_count_d = word_count_q + 1'b1;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_flush_q   <= 1'b0;
      addr_out_q   <= '0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      wr_en_q      <= wr_en_d;
      wr_flush_q   <= wr_flush_d;
      addr_out_q   <= addr_out_d;
      data_out_q   <= data_out_d;
    end
  end

  assign addr_out   = addr_out_q;
  assign data_out   = data_out_q;
  assign wr_en      = wr_en_q;
  assign wr_flush   = wr_flush_q;
  assign word_count = word_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_sector_write_deser.sv
// Bench for sector_write_deser: two configurations driven in
// parallel and compared every cycle against a sector-level model.
module tb_sector_write_deser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_data = 1'b0;
  logic new_data = 1'b0;
  logic data_area = 1'b0;

  logic [1:0] a_addr;
  logic [7:0] a_data;
  logic       a_wr, a_fl, a_ovf;
  logic [2:0] a_cnt;
  logic [2:0] b_addr;
  logic [7:0] b_data;
  logic       b_wr, b_fl, b_ovf;
  logic [3:0] b_cnt;

  always #5 clk = ~clk;

  sector_write_deser #(
    .WORD_W(8), .ADDR_W(2), .SYNC_EN(1'b1),
    .MSB_FIRST(1'b1), .PAD_BIT(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .wr_data(wr_data),
    .new_data(new_data), .data_area(data_area),
    .addr_out(a_addr), .data_out(a_data), .wr_en(a_wr),
    .wr_flush(a_fl), .word_count(a_cnt), .overflow(a_ovf)
  );

  sector_write_deser #(
    .WORD_W(8), .ADDR_W(3), .SYNC_EN(1'b0),
    .MSB_FIRST(1'b0), .PAD_BIT(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .wr_data(wr_data),
    .new_data(new_data), .data_area(data_area),
    .addr_out(b_addr), .data_out(b_data), .wr_en(b_wr),
    .wr_flush(b_fl), .word_count(b_cnt), .overflow(b_ovf)
  );

  int n_vec = 0;
  int n_err = 0;

  // model: 0 idle, 1 in area, 2 padded write done, 3 flush cycle
  int          ph[2];
  int          nb[2];
  int          nw[2];
  bit [31:0]   bits[2];
  bit          synced[2];
  bit          m_ovf[2];
  bit          e_wr[2];
  bit          e_fl[2];
  int          e_addr[2];
  int          e_data[2];

  int wa[$];
  int wb[$];
  int fa, fb, fa_ovf;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit cfg_sync(int c);
    return c == 0;
  endfunction

  function automatic bit cfg_msb(int c);
    return c == 0;
  endfunction

  function automatic bit cfg_pad(int c);
    return c == 1;
  endfunction

  function automatic int cfg_depth(int c);
    return (c == 0) ? 4 : 8;
  endfunction

  function automatic int make_word(int c);
    int w = 0;
    for (int i = 0; i < 8; i++) begin
      int v = (i < nb[c]) ? int'(bits[c][i]) : int'(cfg_pad(c));
      int pos = cfg_msb(c) ? 7 - i : i;
      w = w | (v << pos);
    end
    return w;
  endfunction

  task automatic m_store(int c, int w);
    if (nw[c] == cfg_depth(c)) begin
      m_ovf[c] = 1'b1;
    end else begin
      e_wr[c]   = 1'b1;
      e_addr[c] = nw[c];
      e_data[c] = w;
      nw[c]++;
    end
  endtask

  task automatic m_start(int c);
    nw[c]     = 0;
    nb[c]     = 0;
    bits[c]   = '0;
    m_ovf[c]  = 1'b0;
    synced[c] = !cfg_sync(c);
    ph[c]     = 1;
  endtask

  task automatic m_reset();
    for (int c = 0; c < 2; c++) begin
      ph[c] = 0; nb[c] = 0; nw[c] = 0; bits[c] = '0;
      synced[c] = 1'b0; m_ovf[c] = 1'b0;
      e_wr[c] = 1'b0; e_fl[c] = 1'b0;
      e_addr[c] = 0; e_data[c] = 0;
    end
  endtask

  task automatic m_step(int c, bit da, bit nd, bit b);
    e_wr[c] = 1'b0;
    e_fl[c] = 1'b0;
    case (ph[c])
      0: begin
        if (da) begin
          m_start(c);
          if (!cfg_sync(c) && nd) begin
            bits[c][0] = b;
            nb[c] = 1;
          end
        end
      end
      1: begin
        if (!da) begin
          if (nb[c] > 0) begin
            m_store(c, make_word(c));
            ph[c] = 2;
          end else begin
            e_fl[c] = 1'b1;
            ph[c] = 3;
          end
          nb[c] = 0;
        end else if (nd) begin
          if (!synced[c]) begin
            synced[c] = b;
          end else begin
            bits[c][nb[c]] = b;
            nb[c]++;
            if (nb[c] == 8) begin
              m_store(c, make_word(c));
              nb[c] = 0;
            end
          end
        end
      end
      2: begin
        e_fl[c] = 1'b1;
        ph[c] = 3;
      end
      default: begin
        if (da) m_start(c);
        else ph[c] = 0;
      end
    endcase
  endtask

  task automatic compare();
    check("A.wr_en", a_wr, e_wr[0]);
    check("A.flush", a_fl, e_fl[0]);
    check("A.count", a_cnt, nw[0]);
    check("A.ovf", a_ovf, m_ovf[0]);
    check("A.addr", a_addr, e_addr[0]);
    check("A.data", a_data, e_data[0]);
    check("B.wr_en", b_wr, e_wr[1]);
    check("B.flush", b_fl, e_fl[1]);
    check("B.count", b_cnt, nw[1]);
    check("B.ovf", b_ovf, m_ovf[1]);
    check("B.addr", b_addr, e_addr[1]);
    check("B.data", b_data, e_data[1]);
    check("A.excl", a_wr & a_fl, 1'b0);
    check("B.excl", b_wr & b_fl, 1'b0);
    if (a_wr) wa.push_back((int'(a_addr) << 8) | int'(a_data));
    if (b_wr) wb.push_back((int'(b_addr) << 8) | int'(b_data));
    if (a_fl) begin
      fa = a_cnt;
      fa_ovf = a_ovf;
    end
    if (b_fl) fb = b_cnt;
  endtask

  task automatic step(bit da, bit nd, bit b);
    @(negedge clk);
    data_area = da;
    new_data  = nd;
    wr_data   = b;
    m_step(0, da, nd, b);
    m_step(1, da, nd, b);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic send_byte(logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(1'b1, 1'b1, v[i]);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_logs();
    wa.delete();
    wb.delete();
    fa = -1;
    fb = -1;
    fa_ovf = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    data_area = 1'b0;
    new_data = 1'b0;
    #1;
    check("rst.A", {a_wr, a_fl, a_ovf, a_cnt, a_addr, a_data}, 0);
    check("rst.B", {b_wr, b_fl, b_ovf, b_cnt, b_addr, b_data}, 0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    m_reset();
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    check("init.A", {a_wr, a_fl, a_ovf, a_cnt, a_addr, a_data}, 0);
    check("init.B", {b_wr, b_fl, b_ovf, b_cnt, b_addr, b_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // two words after a preamble and sync bit
    clear_logs();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    send_byte(8'hA5);
    send_byte(8'h3C);
    idle(4);
    check("t1.nwr", wa.size(), 2);
    check("t1.w0", (wa.size() > 0) ? wa[0] : -1, 32'h0A5);
    check("t1.w1", (wa.size() > 1) ? wa[1] : -1, 32'h13C);
    check("t1.cnt", fa, 2);
    check("t1.ovf", fa_ovf, 0);

    // full word then a 3-bit partial word
    clear_logs();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    send_byte(8'hFF);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("t2.pad", {a_wr, a_fl}, 2'b10);
    step(1'b0, 1'b0, 1'b0);
    check("t2.fl", {a_wr, a_fl}, 2'b01);
    idle(2);
    check("t2.w0", (wa.size() > 0) ? wa[0] : -1, 32'h0FF);
    check("t2.w1", (wa.size() > 1) ? wa[1] : -1, 32'h1A0);
    check("t2.cnt", fa, 2);

    // six words into a four-word buffer
    clear_logs();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) send_byte(8'($urandom));
    idle(3);
    check("t3.nwr", wa.size(), 4);
    check("t3.last", (wa.size() > 3) ? (wa[3] >> 8) : -1, 3);
    check("t3.cnt", fa, 4);
    check("t3.ovf", fa_ovf, 1);
    check("t3.addr", a_addr, 3);

    // forty cycles of zeros only
    clear_logs();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t4.fl", a_fl, 1'b1);
    idle(2);
    check("t4.nwr", wa.size(), 0);
    check("t4.cnt", fa, 0);

    // LSB-first word, bit on the falling edge is dropped
    clear_logs();
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    idle(3);
    check("t5.nwr", wb.size(), 1);
    check("t5.w0", (wb.size() > 0) ? wb[0] : -1, 32'h001);
    check("t5.cnt", fb, 1);

    // reset in the middle of a sector
    clear_logs();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 19; i++) step(1'b1, 1'b1, 1'($urandom));
    do_reset();
    idle(3);
    check("t6.nofl", fa, -1);
    clear_logs();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    send_byte(8'h5A);
    idle(3);
    check("t6.w0", (wa.size() > 0) ? wa[0] : -1, 32'h05A);
    check("t6.cnt", fa, 1);

    // randomized sectors, gaps and occasional resets
    for (int s = 0; s < 40; s++) begin
      int len = $urandom_range(0, 60);
      int rcut = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 60) : -1;
      for (int i = 0; i < len; i++) begin
        if (i == rcut) begin
          do_reset();
          break;
        end
        step(1'b1, 1'($urandom_range(0, 2) != 0), 1'($urandom));
      end
      for (int g = $urandom_range(1, 4); g > 0; g--)
        step(1'b0, 1'($urandom), 1'($urandom));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
